// File: rtl/recirculator_param_if.sv
// Lane bus between the idle logic / test source and the recirculator.
// Latency: none, this is wiring only.
// Backpressure: none; valids are per lane and there is no ready signal.
interface recirculator_param_if #(
    parameter int LANES  = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    logic                      idle_in;
    logic                      clear_counts;
    logic [LANES*DATA_W-1:0]   data_in;
    logic [LANES-1:0]          valid_in;
    logic [LANES*DATA_W-1:0]   fwd_data;
    logic [LANES-1:0]          fwd_valid;
    logic [LANES*DATA_W-1:0]   rcv_data;
    logic [LANES-1:0]          rcv_valid;
    logic                      mode;
    logic                      switch_pending;
    logic [CNT_W-1:0]          fwd_words;
    logic [CNT_W-1:0]          rcv_words;

    // Source side: drives lane words and control, observes both paths.
    modport master (
        output idle_in, clear_counts, data_in, valid_in,
        input  fwd_data, fwd_valid, rcv_data, rcv_valid,
        input  mode, switch_pending, fwd_words, rcv_words
    );

    // Router side.
    modport slave (
        input  idle_in, clear_counts, data_in, valid_in,
        output fwd_data, fwd_valid, rcv_data, rcv_valid,
        output mode, switch_pending, fwd_words, rcv_words
    );
endinterface

// File: rtl/recirculator_param.sv
// Lane router: steers registered lane words to the recirculate or forward path, switching only on bubbles.
// Latency: 1 cycle from data_in/valid_in to the selected path; mode changes after the deciding edge.
// Backpressure: none; every valid word is accepted and routed, and a pending switch waits for a bubble.
module recirculator_param #(
    parameter int LANES  = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    recirculator_param_if.slave  io
);
    // Encoding is {mode, pending}, so the status outputs are plain bits of the state register.
    typedef enum logic [1:0] {
        RECIRC   = 2'b00,
        PEND_FWD = 2'b01,
        FORWARD  = 2'b10,
        PEND_RCV = 2'b11
    } state_t;

    localparam int SUM_W = CNT_W + 4;  // headroom for adding up to 15 words before saturating

    state_t                  state_q, state_d;
    logic [LANES*DATA_W-1:0] fwd_data_q, fwd_data_d;
    logic [LANES-1:0]        fwd_valid_q, fwd_valid_d;
    logic [LANES*DATA_W-1:0] rcv_data_q, rcv_data_d;
    logic [LANES-1:0]        rcv_valid_q, rcv_valid_d;
    logic [CNT_W-1:0]        fwd_words_q, fwd_words_d;
    logic [CNT_W-1:0]        rcv_words_q, rcv_words_d;

    logic                    bubble;
    logic                    fwd_active;
    logic [3:0]              pop;

    assign bubble     = (io.valid_in == '0);
    assign fwd_active = state_q[1];

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt, input logic [3:0] inc);
        logic [SUM_W-1:0] sum;
        logic [CNT_W-1:0] max_val;
        max_val = '1;
        sum     = SUM_W'(cnt) + SUM_W'(inc);
        if (sum > SUM_W'(max_val)) begin
            sat_add = max_val;
        end else begin
            sat_add = sum[CNT_W-1:0];
        end
    endfunction

    // Next steering state: a mode change is committed only on a bubble so bursts stay on one path.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RECIRC: begin
                if (io.idle_in) state_d = bubble ? FORWARD : PEND_FWD;
            end
            PEND_FWD: begin
                if (!io.idle_in)  state_d = RECIRC;
                else if (bubble)  state_d = FORWARD;
            end
            FORWARD: begin
                if (!io.idle_in) state_d = bubble ? RECIRC : PEND_RCV;
            end
            PEND_RCV: begin
                if (io.idle_in)   state_d = FORWARD;
                else if (bubble)  state_d = RECIRC;
            end
            default: state_d = RECIRC;
        endcase
    end

    // Number of valid lanes this cycle.
    always_comb begin
        pop = '0;
        for (int i = 0; i < LANES; i++) begin
            pop = pop + 4'(io.valid_in[i]);
        end
    end

    // Path loads use the pre-edge state; the idle path keeps its data and drops its valids.
    always_comb begin
        fwd_data_d  = fwd_data_q;
        fwd_valid_d = '0;
        rcv_data_d  = rcv_data_q;
        rcv_valid_d = '0;
        if (fwd_active) begin
            fwd_data_d  = io.data_in;
            fwd_valid_d = io.valid_in;
        end else begin
            rcv_data_d  = io.data_in;
            rcv_valid_d = io.valid_in;
        end
    end

    // Word counters: clear wins over this cycle's increment; only the active path counts.
    always_comb begin
        fwd_words_d = fwd_words_q;
        rcv_words_d = rcv_words_q;
        if (io.clear_counts) begin
            fwd_words_d = '0;
            rcv_words_d = '0;
        end else if (fwd_active) begin
            fwd_words_d = sat_add(fwd_words_q, pop);
        end else begin
            rcv_words_d = sat_add(rcv_words_q, pop);
        end
    end

    // State, path and counter registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RECIRC;
            fwd_data_q  <= '0;
            fwd_valid_q <= '0;
            rcv_data_q  <= '0;
            rcv_valid_q <= '0;
            fwd_words_q <= '0;
            rcv_words_q <= '0;
        end else begin
            state_q     <= state_d;
            fwd_data_q  <= fwd_data_d;
            fwd_valid_q <= fwd_valid_d;
            rcv_data_q  <= rcv_data_d;
            rcv_valid_q <= rcv_valid_d;
            fwd_words_q <= fwd_words_d;
            rcv_words_q <= rcv_words_d;
        end
    end

    assign io.fwd_data       = fwd_data_q;
    assign io.fwd_valid      = fwd_valid_q;
    assign io.rcv_data       = rcv_data_q;
    assign io.rcv_valid      = rcv_valid_q;
    assign io.mode           = state_q[1];
    assign io.switch_pending = state_q[0];
    assign io.fwd_words      = fwd_words_q;
    assign io.rcv_words      = rcv_words_q;
endmodule

// File: tb/tb_recirculator_param.sv
// Directed table-driven bench for recirculator_param (default build plus a CNT_W=4 copy for saturation).
// Latency: each vector is applied before an edge and checked 1 time unit after it.
// Backpressure: not applicable; the bench only drives valids.
module tb_recirculator_param;
    logic clk;
    logic reset;

    recirculator_param_if #(.LANES(4), .DATA_W(8), .CNT_W(16)) bus ();
    recirculator_param_if #(.LANES(4), .DATA_W(8), .CNT_W(4))  bus4 ();

    recirculator_param #(.LANES(4), .DATA_W(8), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus.slave)
    );

    recirculator_param #(.LANES(4), .DATA_W(8), .CNT_W(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .io    (bus4.slave)
    );

    // The narrow-counter copy sees exactly the same stimulus.
    assign bus4.idle_in      = bus.idle_in;
    assign bus4.clear_counts = bus.clear_counts;
    assign bus4.data_in      = bus.data_in;
    assign bus4.valid_in     = bus.valid_in;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  fv;
        logic [31:0] fd;
        logic [3:0]  rv;
        logic [31:0] rd;
        logic        mode;
        logic        pend;
        logic [15:0] fw;
        logic [15:0] rw;
        logic [3:0]  fw4;
    } obs_t;

    typedef struct packed {
        logic        idle;
        logic        clr;
        logic [3:0]  v;
        logic [31:0] d;
        obs_t        exp;
    } vec_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t vq[$];

    function automatic vec_t mk(input logic idle, input logic clr, input logic [3:0] v, input logic [31:0] d,
                                input logic [3:0] fv, input logic [31:0] fd,
                                input logic [3:0] rv, input logic [31:0] rd,
                                input logic mode, input logic pend,
                                input logic [15:0] fw, input logic [15:0] rw, input logic [3:0] fw4);
        vec_t r;
        r.idle     = idle;
        r.clr      = clr;
        r.v        = v;
        r.d        = d;
        r.exp.fv   = fv;
        r.exp.fd   = fd;
        r.exp.rv   = rv;
        r.exp.rd   = rd;
        r.exp.mode = mode;
        r.exp.pend = pend;
        r.exp.fw   = fw;
        r.exp.rw   = rw;
        r.exp.fw4  = fw4;
        return r;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.fv   = bus.fwd_valid;
        o.fd   = bus.fwd_data;
        o.rv   = bus.rcv_valid;
        o.rd   = bus.rcv_data;
        o.mode = bus.mode;
        o.pend = bus.switch_pending;
        o.fw   = bus.fwd_words;
        o.rw   = bus.rcv_words;
        o.fw4  = bus4.fwd_words;
        return o;
    endfunction

    task automatic check(input string name, input obs_t exp);
        obs_t act;
        act = sample();
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got fv=%h fd=%h rv=%h rd=%h mode=%b pend=%b fw=%0d rw=%0d fw4=%0d; want fv=%h fd=%h rv=%h rd=%h mode=%b pend=%b fw=%0d rw=%0d fw4=%0d",
                     name, act.fv, act.fd, act.rv, act.rd, act.mode, act.pend, act.fw, act.rw, act.fw4,
                     exp.fv, exp.fd, exp.rv, exp.rd, exp.mode, exp.pend, exp.fw, exp.rw, exp.fw4);
        end
    endtask

    task automatic apply(input vec_t vec, input string name);
        bus.idle_in      = vec.idle;
        bus.clear_counts = vec.clr;
        bus.valid_in     = vec.v;
        bus.data_in      = vec.d;
        @(posedge clk);
        #1;
        check(name, vec.exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t zero;
        vec_t post;
        zero = '0;

        // Plain recirculation after reset
        vq.push_back(mk(0,0,4'hF,32'h44332211, 4'h0,32'h0, 4'hF,32'h44332211, 0,0,  0, 4, 0));
        vq.push_back(mk(0,0,4'hF,32'h44332211, 4'h0,32'h0, 4'hF,32'h44332211, 0,0,  0, 8, 0));
        vq.push_back(mk(0,0,4'hF,32'h44332211, 4'h0,32'h0, 4'hF,32'h44332211, 0,0,  0,12, 0));
        // Forward request during a 5-cycle burst: pending, all words stay on rcv
        vq.push_back(mk(1,0,4'hF,32'h11111111, 4'h0,32'h0, 4'hF,32'h11111111, 0,1,  0,16, 0));
        vq.push_back(mk(1,0,4'hF,32'h22222222, 4'h0,32'h0, 4'hF,32'h22222222, 0,1,  0,20, 0));
        vq.push_back(mk(1,0,4'hF,32'h33333333, 4'h0,32'h0, 4'hF,32'h33333333, 0,1,  0,24, 0));
        vq.push_back(mk(1,0,4'hF,32'h44444444, 4'h0,32'h0, 4'hF,32'h44444444, 0,1,  0,28, 0));
        vq.push_back(mk(1,0,4'hF,32'h55555555, 4'h0,32'h0, 4'hF,32'h55555555, 0,1,  0,32, 0));
        // Bubble commits the switch; next word goes forward
        vq.push_back(mk(1,0,4'h0,32'h00000000, 4'h0,32'h0, 4'h0,32'h00000000, 1,0,  0,32, 0));
        vq.push_back(mk(1,0,4'hF,32'hA5A5A5A5, 4'hF,32'hA5A5A5A5, 4'h0,32'h0, 1,0,  4,32, 4));
        // Clear, then three cycles of 0101, then clear beating a full word
        vq.push_back(mk(1,1,4'h5,32'h00AA00BB, 4'h5,32'h00AA00BB, 4'h0,32'h0, 1,0,  0, 0, 0));
        vq.push_back(mk(1,0,4'h5,32'h00AA00BB, 4'h5,32'h00AA00BB, 4'h0,32'h0, 1,0,  2, 0, 2));
        vq.push_back(mk(1,0,4'h5,32'h00AA00BB, 4'h5,32'h00AA00BB, 4'h0,32'h0, 1,0,  4, 0, 4));
        vq.push_back(mk(1,0,4'h5,32'h00AA00BB, 4'h5,32'h00AA00BB, 4'h0,32'h0, 1,0,  6, 0, 6));
        vq.push_back(mk(1,1,4'hF,32'hA5A5A5A5, 4'hF,32'hA5A5A5A5, 4'h0,32'h0, 1,0,  0, 0, 0));
        // Five full words forward: narrow counter saturates at 15
        vq.push_back(mk(1,0,4'hF,32'hC3C3C3C3, 4'hF,32'hC3C3C3C3, 4'h0,32'h0, 1,0,  4, 0, 4));
        vq.push_back(mk(1,0,4'hF,32'hC3C3C3C3, 4'hF,32'hC3C3C3C3, 4'h0,32'h0, 1,0,  8, 0, 8));
        vq.push_back(mk(1,0,4'hF,32'hC3C3C3C3, 4'hF,32'hC3C3C3C3, 4'h0,32'h0, 1,0, 12, 0,12));
        vq.push_back(mk(1,0,4'hF,32'hC3C3C3C3, 4'hF,32'hC3C3C3C3, 4'h0,32'h0, 1,0, 16, 0,15));
        vq.push_back(mk(1,0,4'hF,32'hC3C3C3C3, 4'hF,32'hC3C3C3C3, 4'h0,32'h0, 1,0, 20, 0,15));
        // FORWARD -> PEND_RCV -> FORWARD (re-request) -> RECIRC on bubble
        vq.push_back(mk(0,0,4'hF,32'h12345678, 4'hF,32'h12345678, 4'h0,32'h0, 1,1, 24, 0,15));
        vq.push_back(mk(1,0,4'hF,32'h87654321, 4'hF,32'h87654321, 4'h0,32'h0, 1,0, 28, 0,15));
        vq.push_back(mk(0,0,4'h0,32'h00000000, 4'h0,32'h00000000, 4'h0,32'h0, 0,0, 28, 0,15));
        vq.push_back(mk(0,0,4'h3,32'h0000CAFE, 4'h0,32'h00000000, 4'h3,32'h0000CAFE, 0,0, 28, 2,15));
        // Withdrawn forward request: back to RECIRC, no forward valids
        vq.push_back(mk(1,0,4'hF,32'hFEEDF00D, 4'h0,32'h0, 4'hF,32'hFEEDF00D, 0,1, 28, 6,15));
        vq.push_back(mk(0,0,4'hF,32'h0BADC0DE, 4'h0,32'h0, 4'hF,32'h0BADC0DE, 0,0, 28,10,15));
        vq.push_back(mk(0,0,4'h0,32'h00000000, 4'h0,32'h0, 4'h0,32'h00000000, 0,0, 28,10,15));
        // idle_in toggling with no bubble: mode never changes
        vq.push_back(mk(1,0,4'hF,32'h01020304, 4'h0,32'h0, 4'hF,32'h01020304, 0,1, 28,14,15));
        vq.push_back(mk(0,0,4'hF,32'h05060708, 4'h0,32'h0, 4'hF,32'h05060708, 0,0, 28,18,15));
        vq.push_back(mk(1,0,4'hF,32'h090A0B0C, 4'h0,32'h0, 4'hF,32'h090A0B0C, 0,1, 28,22,15));
        // Into FORWARD again for the mid-burst reset
        vq.push_back(mk(1,0,4'h0,32'h00000000, 4'h0,32'h0, 4'h0,32'h00000000, 1,0, 28,22,15));
        vq.push_back(mk(1,0,4'hF,32'h13579BDF, 4'hF,32'h13579BDF, 4'h0,32'h0, 1,0, 32,22,15));

        post = mk(0,0,4'hF,32'h2468ACE0, 4'h0,32'h0, 4'hF,32'h2468ACE0, 0,0, 0,4,0);

        reset            = 1'b1;
        bus.idle_in      = 1'b0;
        bus.clear_counts = 1'b0;
        bus.valid_in     = '0;
        bus.data_in      = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_state", zero);
        reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            apply(vq[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset mid-burst in FORWARD: outputs clear before the next edge
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_midburst", zero);
        @(posedge clk);
        #1;
        check("reset_held_edge", zero);
        reset = 1'b0;
        apply(post, "after_reset_rcv");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/recirculator_param.md
# recirculator_param

Parametrised lane router between the idle-state logic and the downstream mux logic. Each cycle it registers LANES words of DATA_W bits with per-lane valids and steers them either back to the test source (recirculate path) or forward to the mux logic (forward path). A 4-state FSM changes the steering mode only on a bus bubble, so no burst is ever split across paths. Saturating word counters on each path support scoreboarding.

## Interface
- LANES, 4, number of parallel lanes (1..8)
- DATA_W, 8, bits per lane word
- CNT_W, 16, width of each word counter
- clk  in  1  single rising-edge clock
- reset  in  1  asynchronous, active-high reset
- idle_in  in  1  1 = idle logic requests forward mode, 0 = recirculate
- clear_counts  in  1  synchronous clear of both counters
- data_in  in  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
- valid_in  in  LANES  per-lane valid
- fwd_data  out  LANES*DATA_W  registered forward-path data
- fwd_valid  out  LANES  registered forward-path valids
- rcv_data  out  LANES*DATA_W  registered recirculate-path data
- rcv_valid  out  LANES  registered recirculate-path valids
- mode  out  1  0 = recirculate active, 1 = forward active (current routing)
- switch_pending  out  1  high while a mode change waits for a bubble
- fwd_words  out  CNT_W  count of valid words sent forward
- rcv_words  out  CNT_W  count of valid words recirculated

## Operation
- Bubble: a cycle with valid_in == 0 (all lanes low).
- States: RECIRC (mode 0), PEND_FWD (mode 0, pending 1), FORWARD (mode 1), PEND_RCV (mode 1, pending 1).
- RECIRC: idle_in=1 and bubble -> FORWARD; idle_in=1 and not bubble -> PEND_FWD; otherwise stay.
- PEND_FWD: idle_in=0 -> RECIRC (request withdrawn); bubble -> FORWARD; else stay.
- FORWARD: idle_in=0 and bubble -> RECIRC; idle_in=0 and not bubble -> PEND_RCV; otherwise stay.
- PEND_RCV: idle_in=1 -> FORWARD; bubble -> RECIRC; else stay.
- Routing uses the state before the edge: mode 0 states load rcv_data/rcv_valid from inputs; mode 1 states load fwd_data/fwd_valid.
- Inactive path: valid forced to 0 every cycle; data holds its last value.
- Lanes are independent; no lane reordering or merging.
- Counters: active path's counter adds popcount(valid_in) (0..LANES) each edge; saturates at 2^CNT_W-1 (no wrap). Inactive counter holds.
- clear_counts=1: both counters load 0 that edge; clear beats increment (that cycle's words are not counted).
- Reset (async assert, any state, mid-burst included): state RECIRC, mode 0, switch_pending 0, all data and valid outputs 0, both counters 0. Deassertion is used synchronously; first edge after deassert routes per RECIRC.

## Timing
- Data latency: 1 cycle, input at edge k appears on the selected path after edge k.
- mode/switch_pending are registered state decodes, valid after the edge that changes state.
- Switch latency: request with bubble at edge k -> mode flips after edge k; first word on new path sampled at edge k+1.
- Pending requests wait indefinitely; no timeout.
- idle_in toggling every cycle with no bubble: state alternates between steady and pending states, mode never changes.
- Counter values reflect words up to and including the last edge.

## Test plan
- Reset then valid_in=4'hF, data_in=32'h44332211, idle_in=0 for 3 cycles -> rcv_valid=4'hF, rcv_data=32'h44332211, fwd_valid=0, rcv_words=12, fwd_words=0.
- RECIRC, idle_in=1 with valid_in=4'hF held 5 cycles then valid_in=0 -> switch_pending=1 for 5 cycles, mode=1 after the bubble edge; all 5 words on rcv only; next word 32'hA5A5A5A5 on fwd_data.
- PEND_FWD, drop idle_in to 0 before any bubble -> state RECIRC, mode stays 0, switch_pending=0, no fwd_valid ever asserted.
- FORWARD, valid_in=4'b0101 for 3 cycles -> fwd_words=6; assert clear_counts with valid_in=4'hF -> fwd_words=0 next cycle, not 4.
- CNT_W=4, forward 5 cycles of valid_in=4'hF -> fwd_words saturates at 15, stays 15.
- Assert reset mid-burst in FORWARD -> immediately (before next edge) all outputs 0, mode 0; after release, words route to rcv path.
